// File: rtl/ravenoc_pkg.sv
// AXI4 type definitions shared by RaveNoC masters and slaves.
package ravenoc_pkg;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_ID_W   = 4;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef struct packed {
    logic [AXI_ID_W-1:0]     awid;
    logic [AXI_ADDR_W-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic [3:0]              awregion;
    logic                    awvalid;
    logic [AXI_DATA_W-1:0]   wdata;
    logic [AXI_DATA_W/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    bready;
    logic [AXI_ID_W-1:0]     arid;
    logic [AXI_ADDR_W-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic [3:0]              arregion;
    logic                    arvalid;
    logic                    rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic                    awready;
    logic                    wready;
    logic [AXI_ID_W-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    arready;
    logic [AXI_ID_W-1:0]     rid;
    logic [AXI_DATA_W-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
  } s_axi_miso_t;
endpackage

// File: rtl/core_dbus_axi_bridge.sv
// Core load/store bus to single AXI4 master bridge.
// Single-beat transactions, up to MAX_OUTSTANDING in flight, responses kept
// in order by never mixing loads and stores in flight. AW and W handshake
// independently. Optional watchdog enabled with macro BUS_TIMEOUT_EN.
module core_dbus_axi_bridge
  import ravenoc_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int AXI_ID          = 0,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  input  logic [1:0]  cmd_size,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output s_axi_mosi_t axi_mosi,
  input  s_axi_miso_t axi_miso
`ifdef BUS_TIMEOUT_EN
  ,
  output logic        timeout_o
`endif
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic             ar_pend;
  logic             aw_pend;
  logic             w_pend;
  logic             pend_wr;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic [1:0]       size_q;
  logic             slots_free;
  logic             beat_in;
  logic             beat;
  logic             accept;
  logic             timeout_blk;
  logic             unused_miso;

  // A beat with nothing in flight is stale (e.g. after reset) and ignored.
  assign slots_free = !ar_pend && !aw_pend && !w_pend;
  assign beat_in    = axi_miso.rvalid || axi_miso.bvalid;
  assign beat       = beat_in && (cnt != '0);
  assign cmd_ready  = !arst && slots_free && (cnt < CNT_W'(MAX_OUTSTANDING)) &&
                      ((cnt == '0) || (cmd_wr == pend_wr)) && !timeout_blk;
  assign accept     = cmd_valid && cmd_ready;

  assign unused_miso = ^{axi_miso.rid, axi_miso.bid, axi_miso.rlast,
                         axi_miso.rresp[0], axi_miso.bresp[0]};

  // Holding-slot flags, in-flight direction and outstanding count.
  always_ff @(posedge clk) begin
    if (arst) begin
      ar_pend <= 1'b0;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      pend_wr <= 1'b0;
      cnt     <= '0;
    end else begin
      if (accept) begin
        pend_wr <= cmd_wr;
        if (cmd_wr) begin
          aw_pend <= 1'b1;
          w_pend  <= 1'b1;
        end else begin
          ar_pend <= 1'b1;
        end
      end else begin
        if (ar_pend && axi_miso.arready) ar_pend <= 1'b0;
        if (aw_pend && axi_miso.awready) aw_pend <= 1'b0;
        if (w_pend && axi_miso.wready)   w_pend  <= 1'b0;
      end
      case ({accept, beat})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Command payload capture; only one slot can be occupied at a time.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= cmd_addr;
      size_q  <= cmd_size;
      wdata_q <= cmd_wdata;
      wstrb_q <= cmd_wstrb;
    end
  end

  // Response stage: one-cycle pulse after each R/B beat.
  always_ff @(posedge clk) begin
    if (arst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= beat;
      rsp_rdata <= (beat && axi_miso.rvalid) ? axi_miso.rdata : '0;
      rsp_err   <= beat && (axi_miso.rvalid ? axi_miso.rresp[1] : axi_miso.bresp[1]);
    end
  end

  // AXI master fields: static attributes plus the held command.
  always_comb begin
    axi_mosi          = '0;
    axi_mosi.awid     = AXI_ID_W'(AXI_ID);
    axi_mosi.awaddr   = addr_q;
    axi_mosi.awsize   = {1'b0, size_q};
    axi_mosi.awburst  = AXI_BURST_INCR;
    axi_mosi.awcache  = 4'b0010;
    axi_mosi.awvalid  = aw_pend;
    axi_mosi.wdata    = wdata_q;
    axi_mosi.wstrb    = wstrb_q;
    axi_mosi.wlast    = 1'b1;
    axi_mosi.wvalid   = w_pend;
    axi_mosi.bready   = 1'b1;
    axi_mosi.arid     = AXI_ID_W'(AXI_ID);
    axi_mosi.araddr   = addr_q;
    axi_mosi.arsize   = {1'b0, size_q};
    axi_mosi.arburst  = AXI_BURST_INCR;
    axi_mosi.arcache  = 4'b0010;
    axi_mosi.arvalid  = ar_pend;
    axi_mosi.rready   = 1'b1;
  end

`ifdef BUS_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic [WD_W-1:0] wd_nxt;

  // Watchdog counts idle cycles while transactions are in flight.
  always_comb begin
    wd_nxt = wd_cnt;
    if ((cnt == '0) || beat_in) begin
      wd_nxt = '0;
    end else if (wd_cnt != WD_W'(TIMEOUT_CYCLES)) begin
      wd_nxt = wd_cnt + WD_W'(1);
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (arst) begin
      wd_cnt    <= '0;
      timeout_o <= 1'b0;
    end else begin
      wd_cnt <= wd_nxt;
      if (wd_nxt == WD_W'(TIMEOUT_CYCLES)) timeout_o <= 1'b1;
    end
  end

  assign timeout_blk = timeout_o;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout_blk = 1'b0;
`endif
endmodule

// File: tb/tb_core_dbus_axi_bridge.sv
// Bench for core_dbus_axi_bridge: directed scenarios with literal
// expectations plus a randomized phase against a transaction-level model.
module tb_core_dbus_axi_bridge;
  import ravenoc_pkg::*;

  localparam int MAX_OUT   = 4;
  localparam int AXI_ID_TB = 3;

  logic        clk = 1'b0;
  logic        arst;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic [1:0]  cmd_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  s_axi_mosi_t axi_mosi;
  s_axi_miso_t axi_miso;
`ifdef BUS_TIMEOUT_EN
  logic        timeout_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  core_dbus_axi_bridge #(
    .MAX_OUTSTANDING(MAX_OUT),
    .AXI_ID(AXI_ID_TB),
    .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk(clk),
    .arst(arst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_wstrb(cmd_wstrb),
    .cmd_size(cmd_size),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .axi_mosi(axi_mosi),
    .axi_miso(axi_miso)
`ifdef BUS_TIMEOUT_EN
    ,
    .timeout_o(timeout_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 50) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  bit          mon_on = 1'b0;
  bit          inflight[$];        // direction of each in-flight transaction, oldest first
  bit          m_ar, m_aw, m_w;    // request expected on the AXI channel
  bit          m_rv, m_re;
  logic [31:0] m_rd, m_addr, m_wdata;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  int          sl_rd, sl_aw, sl_w;  // slave-side accepted requests not yet answered
  bit          exp_rdy, acc, k;

  always @(negedge clk) begin
    if (mon_on) begin
      exp_rdy = !arst && !m_ar && !m_aw && !m_w && (inflight.size() < MAX_OUT) &&
                (inflight.size() == 0 || cmd_wr == inflight[0]);
      chk("cmd_ready", cmd_ready, exp_rdy);
      chk("rsp_valid", rsp_valid, m_rv);
      if (m_rv) begin
        chk("rsp_rdata", rsp_rdata, m_rd);
        chk("rsp_err", rsp_err, m_re);
      end
      chk("arvalid", axi_mosi.arvalid, m_ar);
      chk("awvalid", axi_mosi.awvalid, m_aw);
      chk("wvalid", axi_mosi.wvalid, m_w);
      chk("rready", axi_mosi.rready, 1);
      chk("bready", axi_mosi.bready, 1);
      if (m_ar) begin
        chk("araddr", axi_mosi.araddr, m_addr);
        chk("arsize", axi_mosi.arsize, {1'b0, m_size});
        chk("arid", axi_mosi.arid, AXI_ID_TB);
        chk("arlen", axi_mosi.arlen, 0);
        chk("arburst", axi_mosi.arburst, 1);
        chk("arcache", axi_mosi.arcache, 2);
      end
      if (m_aw) begin
        chk("awaddr", axi_mosi.awaddr, m_addr);
        chk("awsize", axi_mosi.awsize, {1'b0, m_size});
        chk("awid", axi_mosi.awid, AXI_ID_TB);
        chk("awlen", axi_mosi.awlen, 0);
      end
      if (m_w) begin
        chk("wdata", axi_mosi.wdata, m_wdata);
        chk("wstrb", axi_mosi.wstrb, m_wstrb);
        chk("wlast", axi_mosi.wlast, 1);
      end
      // advance to the state after the coming rising edge
      if (arst) begin
        inflight.delete();
        {m_ar, m_aw, m_w, m_rv, m_re} = '0;
        m_rd = '0;
        sl_rd = 0; sl_aw = 0; sl_w = 0;
      end else begin
        acc = cmd_valid && exp_rdy;
        if (m_ar && axi_miso.arready) begin m_ar = 1'b0; sl_rd++; end
        if (m_aw && axi_miso.awready) begin m_aw = 1'b0; sl_aw++; end
        if (m_w && axi_miso.wready)   begin m_w  = 1'b0; sl_w++;  end
        if (axi_miso.rvalid && sl_rd > 0) sl_rd--;
        if (axi_miso.bvalid && sl_aw > 0 && sl_w > 0) begin sl_aw--; sl_w--; end
        m_rv = 1'b0;
        if ((axi_miso.rvalid || axi_miso.bvalid) && inflight.size() > 0) begin
          k    = inflight.pop_front();
          m_rv = 1'b1;
          m_rd = k ? 32'h0 : axi_miso.rdata;
          m_re = axi_miso.rvalid ? axi_miso.rresp[1] : axi_miso.bresp[1];
        end
        if (acc) begin
          inflight.push_back(cmd_wr);
          if (cmd_wr) begin m_aw = 1'b1; m_w = 1'b1; end
          else m_ar = 1'b1;
          m_addr = cmd_addr; m_size = cmd_size; m_wdata = cmd_wdata; m_wstrb = cmd_wstrb;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation did not finish");
  end

  // ---------------- stimulus ----------------
  int n_acc;
  bit cur_wr;
  bit done;

  initial begin
    arst = 1'b1; cmd_valid = 0; cmd_wr = 0; cmd_addr = 0; cmd_wdata = 0;
    cmd_wstrb = 0; cmd_size = 0; axi_miso = '0;
    repeat (2) step();
    mon_on = 1'b1;
    @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_arvalid", axi_mosi.arvalid, 0);
    chk("reset_awvalid", axi_mosi.awvalid, 0);
    chk("reset_wvalid", axi_mosi.wvalid, 0);
    step();
    arst = 1'b0;

    // single load
    axi_miso.arready = 1; axi_miso.awready = 1; axi_miso.wready = 1;
    cmd_valid = 1; cmd_wr = 0; cmd_addr = 32'h1000; cmd_size = 2;
    @(negedge clk); chk("load_ready", cmd_ready, 1);
    step(); cmd_valid = 0;
    @(negedge clk);
    chk("load_arvalid", axi_mosi.arvalid, 1);
    chk("load_araddr", axi_mosi.araddr, 32'h1000);
    chk("load_arsize", axi_mosi.arsize, 2);
    chk("load_arlen", axi_mosi.arlen, 0);
    step(); axi_miso.rvalid = 1; axi_miso.rdata = 32'hDEADBEEF; axi_miso.rresp = 0;
    step(); axi_miso.rvalid = 0;
    @(negedge clk);
    chk("load_rsp_valid", rsp_valid, 1);
    chk("load_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("load_rsp_err", rsp_err, 0);
    step();
    @(negedge clk); chk("load_rsp_pulse", rsp_valid, 0);

    // store, W taken three cycles before AW, SLVERR response
    axi_miso.awready = 0; axi_miso.wready = 1;
    cmd_valid = 1; cmd_wr = 1; cmd_addr = 32'h2000; cmd_wdata = 32'hA5A5_0000;
    cmd_wstrb = 4'b1100; cmd_size = 2;
    step(); cmd_valid = 0;
    @(negedge clk);
    chk("st_wvalid", axi_mosi.wvalid, 1);
    chk("st_wdata", axi_mosi.wdata, 32'hA5A5_0000);
    chk("st_wstrb", axi_mosi.wstrb, 4'b1100);
    step(); axi_miso.wready = 0;
    @(negedge clk); chk("st_ready_wait1", cmd_ready, 0);
    step();
    @(negedge clk); chk("st_ready_wait2", cmd_ready, 0);
    step(); axi_miso.awready = 1;
    @(negedge clk);
    chk("st_awvalid_late", axi_mosi.awvalid, 1);
    chk("st_awaddr", axi_mosi.awaddr, 32'h2000);
    chk("st_ready_wait3", cmd_ready, 0);
    step(); axi_miso.bvalid = 1; axi_miso.bresp = 2'b10;
    @(negedge clk); chk("st_awvalid_done", axi_mosi.awvalid, 0);
    step(); axi_miso.bvalid = 0; axi_miso.bresp = 0; axi_miso.wready = 1;
    @(negedge clk);
    chk("st_rsp_valid", rsp_valid, 1);
    chk("st_rsp_err", rsp_err, 1);
    chk("st_rsp_rdata", rsp_rdata, 0);
    step();

    // outstanding limit
    cmd_wr = 0; cmd_size = 2; cmd_valid = 1; cmd_addr = 32'h3000; n_acc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cmd_ready) n_acc++;
      step();
      cmd_addr = 32'h3000 + 32'(n_acc * 4);
    end
    chk("limit_accepts", n_acc, 4);
    @(negedge clk); chk("limit_ready", cmd_ready, 0);
    step(); axi_miso.rvalid = 1; axi_miso.rdata = 32'h1111_2222;
    step(); axi_miso.rvalid = 0;
    n_acc = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (cmd_ready && cmd_valid) n_acc++;
      step();
      if (n_acc == 1) cmd_valid = 0;
    end
    chk("limit_fifth_accept", n_acc, 1);
    for (int i = 0; i < 4; i++) begin
      axi_miso.rvalid = 1; axi_miso.rdata = $urandom; axi_miso.rresp = 2'(i);
      step();
    end
    axi_miso.rvalid = 0;
    repeat (2) step();

    // ordering: store waits for two loads to drain
    cmd_wr = 0; cmd_valid = 1; cmd_addr = 32'h4000;
    repeat (4) step();
    cmd_wr = 1; cmd_wdata = 32'h1234_5678; cmd_wstrb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("order_store_blocked", cmd_ready, 0);
      step();
    end
    axi_miso.rvalid = 1; axi_miso.rdata = 32'h0BAD_F00D;
    step(); step();
    axi_miso.rvalid = 0;
    @(negedge clk); chk("order_store_after_drain", cmd_ready, 1);
    step(); cmd_valid = 0;
    step(); axi_miso.bvalid = 1; axi_miso.bresp = 0;
    step(); axi_miso.bvalid = 0;
    step();

    // reset with three loads in flight, then late R beats
    cmd_wr = 0; cmd_valid = 1; cmd_addr = 32'h5000;
    repeat (6) step();
    cmd_valid = 0; arst = 1;
    step(); arst = 0;
    for (int i = 0; i < 4; i++) begin
      axi_miso.rvalid = (i < 3); axi_miso.rdata = $urandom;
      @(negedge clk);
      chk("rst_stray_rsp", rsp_valid, 0);
      chk("rst_ready", cmd_ready, 1);
      step();
    end
    axi_miso.rvalid = 0;

    // randomized traffic
    cur_wr = 0;
    for (int c = 0; c < 4000; c++) begin
      cmd_valid = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 9) == 0) cur_wr = ~cur_wr;
      cmd_wr = cur_wr;
      cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
      cmd_size = 2'($urandom_range(0, 2));
      axi_miso.arready = ($urandom_range(0, 3) != 0);
      axi_miso.awready = ($urandom_range(0, 3) != 0);
      axi_miso.wready  = ($urandom_range(0, 3) != 0);
      axi_miso.rvalid = 0; axi_miso.bvalid = 0;
      axi_miso.rid = 4'($urandom); axi_miso.bid = 4'($urandom); axi_miso.rlast = 1;
      if (sl_rd > 0 && $urandom_range(0, 2) == 0) begin
        axi_miso.rvalid = 1; axi_miso.rdata = $urandom; axi_miso.rresp = 2'($urandom);
      end else if (sl_aw > 0 && sl_w > 0 && $urandom_range(0, 2) == 0) begin
        axi_miso.bvalid = 1; axi_miso.bresp = 2'($urandom);
      end
      arst = ($urandom_range(0, 599) == 0);
      step();
    end

    // drain everything still in flight
    arst = 0; cmd_valid = 0; done = 0;
    axi_miso.arready = 1; axi_miso.awready = 1; axi_miso.wready = 1;
    for (int c = 0; c < 300 && !done; c++) begin
      axi_miso.rvalid = 0; axi_miso.bvalid = 0;
      if (sl_rd > 0) begin
        axi_miso.rvalid = 1; axi_miso.rdata = $urandom; axi_miso.rresp = 2'($urandom);
      end else if (sl_aw > 0 && sl_w > 0) begin
        axi_miso.bvalid = 1; axi_miso.bresp = 2'($urandom);
      end
      step();
      if (inflight.size() == 0 && sl_rd == 0 && sl_aw == 0 && sl_w == 0 && !m_ar && !m_aw && !m_w)
        done = 1;
    end
    axi_miso.rvalid = 0; axi_miso.bvalid = 0;
    chk("drain_bound", done, 1);
    step();
    @(negedge clk); chk("drain_idle_ready", cmd_ready, 1);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
